acc_mq_datapath: RTL and testbench

Parametrised accumulator/multiplier datapath: the next-generation Acc/MQ/DR register file with an ALU and a shift-add sequencer.
- Replaces the fixed 8-bit, implicit-control datapath with a `WIDTH`-generic block.
- Has an explicit start/ready/done handshake, carry and zero flags, and a multi-cycle unsigned multiply.
- Sits between the shared `inBUS`/`outBUS` and the instruction controller.

---
 rtl/acc_mq_pkg.sv | 24 ++
 rtl/acc_mq_datapath_if.sv | 25 ++
 rtl/acc_alu.sv | 40 ++++
 rtl/acc_mq_datapath.sv | 127 ++++++++++++
 tb/tb_acc_mq_datapath.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_mq_pkg.sv
// Shared opcodes, sequencer states and width helpers for the Acc/MQ/DR datapath.
package acc_mq_pkg;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_e;

   // Add/sub results carry one extra bit for the carry/borrow.
   function automatic int unsigned addsub_width(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/acc_mq_datapath_if.sv
// Bus/control bundle between the instruction controller and the Acc/MQ/DR datapath.
interface acc_mq_datapath_if #(
   parameter int unsigned WIDTH = 8
);
   logic [2:0]       INS;
   logic             start;
   logic             LDAcc, LDMQ, LDDR;
   logic             STAcc, STMQ, STDR;
   logic [WIDTH-1:0] inBUS;
   logic [WIDTH-1:0] outBUS;
   logic             RDY;
   logic             done;
   logic             carry;
   logic             zero;

   modport master (
      output INS, start, LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, inBUS,
      input  outBUS, RDY, done, carry, zero
   );

   modport slave (
      input  INS, start, LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, inBUS,
      output outBUS, RDY, done, carry, zero
   );
endinterface

// File: rtl/acc_alu.sv
// Combinational ALU: Acc op DR with carry; shared by single-cycle ops and the MUL add step.
module acc_alu
   import acc_mq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);
   localparam int unsigned AW = addsub_width(WIDTH);

   logic [AW-1:0] sum;
   logic [AW-1:0] diff;

   always_comb begin
      sum      = {1'b0, a_i} + {1'b0, b_i};
      diff     = {1'b0, a_i} - {1'b0, b_i};
      result_o = a_i;
      carry_o  = 1'b0;
      case (op_i)
         OP_PASS: result_o = b_i;
         OP_ADD: begin
            result_o = sum[WIDTH-1:0];
            carry_o  = sum[WIDTH];
         end
         // Carry reports "no borrow", i.e. a >= b unsigned.
         OP_SUB: begin
            result_o = diff[WIDTH-1:0];
            carry_o  = ~diff[WIDTH];
         end
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         default: result_o = a_i;
      endcase
   end
endmodule

// File: rtl/acc_mq_datapath.sv
// Acc/MQ/DR register file with ALU, flags and a shift-add multiply sequencer.
module acc_mq_datapath
   import acc_mq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic               clock,
   input logic               reset_n,
   acc_mq_datapath_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] dr_q, dr_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             any_ld;
   logic             step_c;
   logic [WIDTH-1:0] step_s;

   assign any_ld = bus.LDAcc | bus.LDMQ | bus.LDDR;
   assign alu_op = (state_q == S_MUL) ? OP_ADD : bus.INS;

   acc_alu #(.WIDTH(WIDTH)) u_alu (
      .op_i     (alu_op),
      .a_i      (acc_q),
      .b_i      (dr_q),
      .result_o (alu_res),
      .carry_o  (alu_c)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      dr_d    = dr_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      step_c  = 1'b0;
      step_s  = acc_q;
      unique case (state_q)
         S_IDLE: begin
            // Any load in the cycle wins and suppresses a coincident start.
            if (any_ld) begin
               if (bus.LDAcc) acc_d = bus.inBUS;
               if (bus.LDMQ)  mq_d  = bus.inBUS;
               if (bus.LDDR)  dr_d  = bus.inBUS;
            end else if (bus.start) begin
               case (bus.INS)
                  OP_MUL: begin
                     acc_d   = '0;
                     carry_d = 1'b0;
                     cnt_d   = CW'(WIDTH);
                     state_d = S_MUL;
                  end
                  OP_SHR: begin
                     {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
                     carry_d       = mq_q[0];
                     zero_d        = ({acc_d, mq_d} == '0);
                     done_d        = 1'b1;
                  end
                  default: begin
                     acc_d   = alu_res;
                     carry_d = alu_c;
                     zero_d  = (alu_res == '0);
                     done_d  = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            if (mq_q[0]) begin
               step_c = alu_c;
               step_s = alu_res;
            end
            {acc_d, mq_d} = {step_c, step_s, mq_q[WIDTH-1:1]};
            cnt_d         = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               zero_d  = ({acc_d, mq_d} == '0);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         dr_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         dr_q    <= dr_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.outBUS = ({WIDTH{bus.STAcc}} & acc_q)
                     | ({WIDTH{bus.STMQ}}  & mq_q)
                     | ({WIDTH{bus.STDR}}  & dr_q);
   assign bus.RDY    = (state_q == S_IDLE);
   assign bus.done   = done_q | (state_q == S_DONE);
   assign bus.carry  = carry_q;
   assign bus.zero   = zero_q;
endmodule

// File: tb/tb_acc_mq_datapath.sv
// Randomised scoreboard bench for acc_mq_datapath (WIDTH=8) with a plain-arithmetic reference model.
module tb_acc_mq_datapath;
   import acc_mq_pkg::*;

   localparam int unsigned W = 8;
   localparam int MASK = 255;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   acc_mq_datapath_if #(.WIDTH(W)) bus ();

   acc_mq_datapath #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    acc;
      int    carry;
      int    zero;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   int acc_m, mq_m, dr_m, carry_m, zero_m;
   string op_names[8] = '{"pass", "add", "sub", "and", "or", "xor", "mul", "shr"};

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: operates on whole numbers, not on the sequencer.
   function automatic exp_t model_op(input int op);
      exp_t e;
      int   s, p, v;
      case (op)
         0: begin acc_m = dr_m; carry_m = 0; end
         1: begin s = acc_m + dr_m; carry_m = (s > MASK) ? 1 : 0; acc_m = s & MASK; end
         2: begin carry_m = (acc_m >= dr_m) ? 1 : 0; acc_m = (acc_m - dr_m) & MASK; end
         3: begin acc_m = acc_m & dr_m; carry_m = 0; end
         4: begin acc_m = acc_m | dr_m; carry_m = 0; end
         5: begin acc_m = acc_m ^ dr_m; carry_m = 0; end
         6: begin
            p = mq_m * dr_m;
            acc_m = p >> W; mq_m = p & MASK; carry_m = 0;
         end
         default: begin
            v = (acc_m << W) | mq_m;
            carry_m = v & 1; v = v >> 1;
            acc_m = v >> W; mq_m = v & MASK;
         end
      endcase
      if (op >= 6) zero_m = (((acc_m << W) | mq_m) == 0) ? 1 : 0;
      else         zero_m = (acc_m == 0) ? 1 : 0;
      e.name = op_names[op]; e.acc = acc_m; e.carry = carry_m; e.zero = zero_m;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding operation.
   always @(negedge clock) begin
      exp_t e;
      if (bus.done) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_done: got done=1, expected no completion");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_acc"},   int'(bus.outBUS), e.acc);
            chk({e.name, "_carry"}, int'(bus.carry),  e.carry);
            chk({e.name, "_zero"},  int'(bus.zero),   e.zero);
         end
      end
   end

   task automatic load(input bit la, input bit lm, input bit ld, input int v);
      bus.LDAcc = la; bus.LDMQ = lm; bus.LDDR = ld; bus.inBUS = 8'(v);
      @(posedge clock); #1;
      bus.LDAcc = 1'b0; bus.LDMQ = 1'b0; bus.LDDR = 1'b0;
      if (la) acc_m = v & MASK;
      if (lm) mq_m  = v & MASK;
      if (ld) dr_m  = v & MASK;
   endtask

   task automatic issue(input int op);
      bus.INS = 3'(op); bus.start = 1'b1;
      sb.push_back(model_op(op));
      @(posedge clock); #1;
      bus.start = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
      #1;
      chk({name, "_drain"}, sb.size(), 0);
   endtask

   task automatic readback(input string name, input bit a, input bit m, input bit d, input int exp);
      bus.STAcc = a; bus.STMQ = m; bus.STDR = d;
      #1;
      chk(name, int'(bus.outBUS), exp);
      bus.STAcc = 1'b1; bus.STMQ = 1'b0; bus.STDR = 1'b0;
      #1;
   endtask

   task automatic mul_timed(input string name);
      int lowcnt, done_at;
      lowcnt = 0; done_at = 0;
      issue(6);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (bus.RDY) break;
         lowcnt++;
         if (bus.done) done_at = i;
      end
      @(posedge clock); #1;
      chk({name, "_rdy_low_cycles"}, lowcnt, W + 1);
      chk({name, "_done_cycle"}, done_at, W + 1);
      chk({name, "_drain"}, sb.size(), 0);
      readback({name, "_mq"}, 1'b0, 1'b1, 1'b0, mq_m);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of run, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int op;
      bus.INS = '0; bus.start = 1'b0;
      bus.LDAcc = 1'b0; bus.LDMQ = 1'b0; bus.LDDR = 1'b0;
      bus.STAcc = 1'b1; bus.STMQ = 1'b0; bus.STDR = 1'b0;
      bus.inBUS = '0;
      acc_m = 0; mq_m = 0; dr_m = 0; carry_m = 0; zero_m = 1;

      repeat (2) @(posedge clock); #1;
      readback("reset_outbus_all", 1'b1, 1'b1, 1'b1, 0);
      chk("reset_zero",  int'(bus.zero),  1);
      chk("reset_carry", int'(bus.carry), 0);
      chk("reset_rdy",   int'(bus.RDY),   1);
      chk("reset_done",  int'(bus.done),  0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // ADD then SUB to exact zero
      load(1, 0, 0, 'hF0);
      load(0, 0, 1, 'h20);
      issue(1);
      chk("add_rdy_stays", int'(bus.RDY), 1);
      drain("add");
      load(0, 0, 1, 'h10);
      issue(2);
      drain("sub");

      // Back-to-back single-cycle starts
      for (int i = 0; i < 8; i++) begin
         op = $urandom_range(0, 6);
         if (op == 6) op = 7;
         bus.INS = 3'(op); bus.start = 1'b1;
         sb.push_back(model_op(op));
         @(posedge clock); #1;
         chk("b2b_rdy", int'(bus.RDY), 1);
      end
      bus.start = 1'b0;
      drain("b2b");

      // Multiply timing and results
      load(0, 1, 0, 'h0B);
      load(0, 0, 1, 'h0D);
      load(1, 0, 0, 'h55);
      mul_timed("mul_11x13");
      load(0, 1, 1, 'hFF);
      mul_timed("mul_ffxff");

      // Start coinciding with a load is dropped
      bus.INS = OP_ADD; bus.start = 1'b1; bus.LDAcc = 1'b1; bus.inBUS = 8'h07;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.LDAcc = 1'b0; acc_m = 'h07;
      repeat (2) @(posedge clock); #1;
      chk("ldstart_acc",   int'(bus.outBUS), acc_m);
      chk("ldstart_carry", int'(bus.carry),  carry_m);
      chk("ldstart_zero",  int'(bus.zero),   zero_m);

      // Start and loads while busy are ignored
      load(0, 1, 0, $urandom_range(1, 255));
      load(0, 0, 1, $urandom_range(1, 255));
      issue(6);
      repeat (2) @(posedge clock); #1;
      bus.INS = OP_ADD; bus.start = 1'b1;
      bus.LDAcc = 1'b1; bus.LDMQ = 1'b1; bus.LDDR = 1'b1; bus.inBUS = 8'($urandom);
      @(posedge clock); #1;
      bus.LDAcc = 1'b0; bus.LDMQ = 1'b0; bus.LDDR = 1'b0;
      @(posedge clock); #1;
      bus.start = 1'b0;
      drain("mul_busy");
      readback("mul_busy_mq", 1'b0, 1'b1, 1'b0, mq_m);
      readback("mul_busy_dr", 1'b0, 1'b0, 1'b1, dr_m);

      // Asynchronous reset in the middle of a multiply
      load(0, 1, 1, 'hB7);
      issue(6);
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      acc_m = 0; mq_m = 0; dr_m = 0; carry_m = 0; zero_m = 1;
      chk("midreset_rdy",   int'(bus.RDY),   1);
      chk("midreset_done",  int'(bus.done),  0);
      chk("midreset_zero",  int'(bus.zero),  1);
      chk("midreset_carry", int'(bus.carry), 0);
      readback("midreset_outbus_all", 1'b1, 1'b1, 1'b1, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      load(0, 1, 0, 'h03);
      load(0, 0, 1, 'h05);
      issue(6);
      drain("mul_3x5");
      readback("mul_3x5_mq", 1'b0, 1'b1, 1'b0, mq_m);

      // Shift right across the Acc/MQ boundary and out of MQ
      load(1, 0, 0, 'h01);
      load(0, 1, 0, 'h00);
      issue(7);
      drain("shr1");
      readback("shr1_mq", 1'b0, 1'b1, 1'b0, mq_m);
      load(1, 0, 0, 'h00);
      load(0, 1, 0, 'h01);
      issue(7);
      drain("shr2");
      readback("shr2_mq", 1'b0, 1'b1, 1'b0, mq_m);

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) load(1, 0, 0, $urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) load(0, 1, 0, $urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) load(0, 0, 1, $urandom_range(0, 255));
         issue($urandom_range(0, 7));
         drain("rand");
         readback("rand_mq", 1'b0, 1'b1, 1'b0, mq_m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
